hamming_frame_rx: RTL
=====================

# hamming_frame_rx

Receive-side deframer and SECDED decoder for the serial link. It takes the demodulated bit stream plus a per-bit strobe and hunts for the 2'b11 sync. It then shifts in the 14-bit code field, corrects single-bit errors and flags double-bit and framing errors. Sits between the FSK demodulator and the LED data register inside the receive top, and is the inverse of the transmit-side Hamming encoder.

## Interface
- BIT_GAP_MIN, 4: minimum clocks between bit_en pulses that the upstream guarantees. Informational only; the bench enforces it.
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- bit_in  in  1  demodulated line bit; valid only when bit_en=1.
- bit_en  in  1  one-cycle strobe, one per received bit.
- hammingcode  out  14  raw code field of the last completed frame.
- data_out  out  8  decoded (corrected) data byte.
- data_valid  out  1  one-cycle pulse when data_out/flags update.
- corrected  out  1  last frame had a single-bit error that was corrected.
- err_double  out  1  last frame had an uncorrectable double error.
- frame_err  out  1  last frame had its stop bit equal to 1.

## Operation
- Frame on the line, first bit first: 1, 1 (sync), codeword positions 12 down to 1, overall parity p0, stop bit 0. Total 16 bits; 14-bit field = {pos12..pos1, p0, stop}.
- Codeword layout:
  - Parity bits at positions 1, 2, 4, 8.
  - Data d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Each parity bit pN is the XOR of the positions whose index has bit N set.
  - p0 makes the XOR of positions 1..12 and p0 equal to 0.
- Line idles at 0. All states below advance only on bit_en, except CHECK and OUT.
- FSM:
  - IDLE: wait for bit_en with bit_in=0 (armed), then go to HUNT.
  - HUNT: bit_en with bit_in=1 goes to SYNC1; bit_in=0 stays in HUNT.
  - SYNC1: bit_en with 1 goes to SHIFT and clears the bit counter; with 0 goes to HUNT.
  - SHIFT: shift bit_in into the LSB of a 14-bit register; the counter counts 0..13. The 14th bit goes to CHECK.
  - CHECK: one cycle. Compute syndrome s[3:0] (XOR of the indices of set positions 1..12) and overall parity q (XOR of all 13 bits). Go to OUT.
  - OUT: one cycle. Register the outputs, pulse data_valid, go to HUNT. Back-to-back frames need no idle 0.
- Decode rules (corrected, err_double):
  - s=0, q=0: clean, flags 0/0.
  - s≠0, q=1: flip position s (s in 1..12), corrected=1. If s>12, set err_double=1 instead.
  - s≠0, q=0: err_double=1; data_out is the uncorrected data bits.
  - s=0, q=1: p0 itself is in error; data is good and corrected=1.
- frame_err = stop bit; it is independent of the decode flags, and data is still output.
- Flags and data_out hold until the next data_valid.

## Timing
- Reset values: data_out=0, hammingcode=0, data_valid=0, corrected=0, err_double=0, frame_err=0; FSM in IDLE; counter 0.
- Reset mid-frame discards the partial frame; no data_valid is produced.
- Latency: data_valid is high on the 2nd rising edge after the edge that samples the stop bit (CHECK, then OUT). All outputs change on that same edge.
- bit_en arriving during CHECK or OUT is a protocol violation (BIT_GAP_MIN ≥ 4 prevents it). The required behaviour is to ignore it.
- bit_en on the same cycle as reset: reset wins.

## Structure
- Shared package hamming_pkg:
  - constants SYNC_BITS=2, CODE_W=14, DATA_W=8, CW_W=12;
  - position-index constants for the parity and data bits;
  - the state enum.
- One sub-module, hamming_secded_dec: purely combinational, 13 bits in, producing data[7:0], corrected, err_double. The transmit encoder uses the same package.

## Test plan
- Send 0xA5 (field 14'h289C, preceded by 1,1) -> data_valid after 2 clocks; data_out=8'hA5; corrected=0, err_double=0, frame_err=0; hammingcode=14'h289C.
- Same frame with position 6 inverted -> data_out=8'hA5, corrected=1, err_double=0.
- Positions 6 and 3 inverted -> err_double=1, corrected=0, data_out=8'hA0 (the uncorrected data bits).
- Stop bit sent as 1 -> frame_err=1, data_out=8'hA5.
- Leading pattern 0,1,0,1,1 then a frame -> exactly one data_valid, which occurs after the second 1 of the final 1,1.
- Assert rst after 7 code bits, then send a full frame -> no pulse for the aborted frame; the next frame decodes correctly.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the serial-link SECDED frame: field widths, codeword
// position map, receive FSM states and syndrome/parity helpers.
package hamming_pkg;

    localparam int SYNC_BITS = 2;
    localparam int CODE_W    = 14;
    localparam int DATA_W    = 8;
    localparam int CW_W      = 12;

    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    localparam int D0_POS = 3;
    localparam int D1_POS = 5;
    localparam int D2_POS = 6;
    localparam int D3_POS = 7;
    localparam int D4_POS = 9;
    localparam int D5_POS = 10;
    localparam int D6_POS = 11;
    localparam int D7_POS = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUNT  = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_SHIFT = 3'd3,
        ST_CHECK = 3'd4,
        ST_OUT   = 3'd5
    } rx_state_e;

    // XOR of the indices of every set position 1..12; zero for a clean word.
    function automatic logic [3:0] calc_syndrome(input logic [CW_W:1] cw);
        logic [3:0] syn;
        syn = 4'd0;
        for (int i = 1; i <= CW_W; i++) begin
            if (cw[i]) begin
                syn = syn ^ 4'(i);
            end else begin
                syn = syn;
            end
        end
        return syn;
    endfunction

    // Overall parity across positions 1..12 and p0 (bit 0).
    function automatic logic calc_parity(input logic [CW_W:0] cw);
        return ^cw;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder: 12 Hamming positions plus overall parity in,
// corrected data byte and error classification out.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [CW_W:0]     code_word,
    output logic [DATA_W-1:0] data,
    output logic              corrected,
    output logic              err_double
);

    localparam logic [3:0] SYN_MAX = 4'(CW_W);

    logic [3:0]  syn_s;
    logic        par_s;
    logic [CW_W:0] flip_mask_s;
    logic [CW_W:0] fixed_s;

    // Classify the error from syndrome and overall parity, then repair a single flip.
    always_comb begin
        syn_s       = calc_syndrome(code_word[CW_W:1]);
        par_s       = calc_parity(code_word);
        flip_mask_s = {(CW_W + 1){1'b0}};
        corrected   = 1'b0;
        err_double  = 1'b0;
        if (syn_s == 4'd0) begin
            // p0 alone is wrong when parity fails; data bits are intact either way
            corrected = par_s;
        end else if (par_s) begin
            if (syn_s <= SYN_MAX) begin
                flip_mask_s = {{CW_W{1'b0}}, 1'b1} << syn_s;
                corrected   = 1'b1;
            end else begin
                err_double  = 1'b1;
            end
        end else begin
            err_double = 1'b1;
        end
        fixed_s = code_word ^ flip_mask_s;
        data    = {fixed_s[D7_POS], fixed_s[D6_POS], fixed_s[D5_POS], fixed_s[D4_POS],
                   fixed_s[D3_POS], fixed_s[D2_POS], fixed_s[D1_POS], fixed_s[D0_POS]};
    end

endmodule

// File: rtl/hamming_frame_rx.sv
// Receive deframer: hunts for the 1,1 sync, shifts in the 14-bit code field
// and publishes the SECDED-decoded byte with error flags.
module hamming_frame_rx
    import hamming_pkg::*;
(
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [CODE_W-1:0] hammingcode,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              corrected,
    output logic              err_double,
    output logic              frame_err
);

    localparam logic [3:0] CNT_LAST = 4'(CODE_W - 1);

    rx_state_e           state_r;
    rx_state_e           next_state_s;
    logic [3:0]          bit_cnt_r;
    logic [CODE_W-1:0]   shift_r;
    logic [DATA_W-1:0]   dec_data_s;
    logic                dec_corr_s;
    logic                dec_dbl_s;
    logic [DATA_W-1:0]   dec_data_r;
    logic                dec_corr_r;
    logic                dec_dbl_r;

    // Field is {pos12..pos1, p0, stop}; the decoder sees everything but the stop bit.
    hamming_secded_dec u_dec (
        .code_word  (shift_r[CODE_W-1:1]),
        .data       (dec_data_s),
        .corrected  (dec_corr_s),
        .err_double (dec_dbl_s)
    );

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; CHECK and OUT advance unconditionally and ignore bit_en.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bit_en && !bit_in) begin
                    next_state_s = ST_HUNT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HUNT: begin
                if (bit_en && bit_in) begin
                    next_state_s = ST_SYNC1;
                end else begin
                    next_state_s = ST_HUNT;
                end
            end
            ST_SYNC1: begin
                if (bit_en) begin
                    next_state_s = bit_in ? ST_SHIFT : ST_HUNT;
                end else begin
                    next_state_s = ST_SYNC1;
                end
            end
            ST_SHIFT: begin
                if (bit_en && (bit_cnt_r == CNT_LAST)) begin
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_CHECK: next_state_s = ST_OUT;
            ST_OUT:   next_state_s = ST_HUNT;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Bit counter, shift register, decode capture and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            bit_cnt_r   <= 4'd0;
            shift_r     <= {CODE_W{1'b0}};
            dec_data_r  <= {DATA_W{1'b0}};
            dec_corr_r  <= 1'b0;
            dec_dbl_r   <= 1'b0;
            hammingcode <= {CODE_W{1'b0}};
            data_out    <= {DATA_W{1'b0}};
            data_valid  <= 1'b0;
            corrected   <= 1'b0;
            err_double  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state_r)
                ST_SYNC1: begin
                    if (bit_en && bit_in) begin
                        bit_cnt_r <= 4'd0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                ST_SHIFT: begin
                    if (bit_en) begin
                        shift_r   <= {shift_r[CODE_W-2:0], bit_in};
                        bit_cnt_r <= (bit_cnt_r == CNT_LAST) ? 4'd0 : bit_cnt_r + 4'd1;
                    end else begin
                        shift_r   <= shift_r;
                    end
                end
                ST_CHECK: begin
                    dec_data_r <= dec_data_s;
                    dec_corr_r <= dec_corr_s;
                    dec_dbl_r  <= dec_dbl_s;
                end
                ST_OUT: begin
                    hammingcode <= shift_r;
                    data_out    <= dec_data_r;
                    corrected   <= dec_corr_r;
                    err_double  <= dec_dbl_r;
                    frame_err   <= shift_r[0];
                    data_valid  <= 1'b1;
                end
                default: begin
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
